// File: rtl/waveform_pkg.sv
// Shared constants for the waveform generator: default period, one-hot
// waveform selects and the quarter-wave sine magnitude table.
package waveform_pkg;

    localparam int PERIOD_DEFAULT = 1000;

    localparam logic [3:0] SEL_SINE     = 4'b0001;
    localparam logic [3:0] SEL_TRIANGLE = 4'b0010;
    localparam logic [3:0] SEL_SQUARE   = 4'b0100;
    localparam logic [3:0] SEL_SAWTOOTH = 4'b1000;

    // L[k] = round(127 * sin(2*pi*(k+0.5)/256)), k = 0..63
    localparam logic [6:0] SINE_L [64] = '{
        7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
        7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
        7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
        7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
        7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
        7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
        7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
    };

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/waveform_gen_sine_quarter_lut.sv
// Combinational quarter-wave sine magnitude lookup (first quadrant only).
module sine_quarter_lut
    import waveform_pkg::*;
(
    input  logic [5:0] addr,
    output logic [6:0] level
);

    assign level = SINE_L[addr];

endmodule

// File: rtl/waveform_gen.sv
// Period-locked DAC waveform generator: 256 samples per PERIOD clocks,
// selectable sine/triangle/square/sawtooth, with a period-sync pulse.
module waveform_gen
    import waveform_pkg::*;
#(
    parameter int PERIOD = PERIOD_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] sel_sig,
    output logic [7:0] dac_out,
    output logic       set,
    output logic [3:0] active_sel
);

    localparam logic [11:0] CNT_LAST = 12'(PERIOD - 1);
    localparam logic [12:0] PERIOD_W = 13'(PERIOD);

    logic [11:0] cnt;
    logic [11:0] acc;
    logic [7:0]  idx;
    logic        wrap;
    logic [12:0] acc_sum;
    logic        acc_carry;
    logic [11:0] acc_next;
    logic [5:0]  lut_addr;
    logic [6:0]  lut_level;
    logic [7:0]  sample;

    assign wrap = (cnt == CNT_LAST);

    // acc + 256 can exceed 12 bits for large PERIOD, so compare in 13 bits
    assign acc_sum   = {1'b0, acc} + 13'd256;
    assign acc_carry = (acc_sum >= PERIOD_W);
    assign acc_next  = acc_carry ? 12'(acc_sum - PERIOD_W) : acc_sum[11:0];

    // Odd quadrants walk the table backwards (63-k == ~k for 6 bits)
    assign lut_addr = idx[6] ? ~idx[5:0] : idx[5:0];

    sine_quarter_lut u_lut (
        .addr  (lut_addr),
        .level (lut_level)
    );

    always_comb begin
        sample = 8'h80;
        case (active_sel)
            SEL_SINE:     sample = idx[7] ? (8'h80 - {1'b0, lut_level})
                                          : (8'h80 + {1'b0, lut_level});
            SEL_TRIANGLE: sample = idx[7] ? {~idx[6:0], 1'b0} : {idx[6:0], 1'b0};
            SEL_SQUARE:   sample = idx[7] ? 8'h00 : 8'hFF;
            SEL_SAWTOOTH: sample = idx;
            default:      sample = 8'h80;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= 12'd0;
            acc        <= 12'd0;
            idx        <= 8'd0;
            set        <= 1'b0;
            active_sel <= SEL_SINE;
            dac_out    <= 8'h80;
        end else if (en) begin
            dac_out <= sample;
            if (wrap) begin
                cnt <= 12'd0;
                acc <= 12'd0;
                idx <= 8'd0;
                set <= 1'b1;
                // Waveform switches only at a period boundary, and only on a clean request
                if (is_onehot4(sel_sig)) begin
                    active_sel <= sel_sig;
                end
            end else begin
                cnt <= cnt + 12'd1;
                acc <= acc_next;
                set <= 1'b0;
                if (acc_carry) begin
                    idx <= idx + 8'd1;
                end
            end
        end else begin
            set <= 1'b0;
        end
    end

endmodule
